jtopl_slot: RTL and testbench

Operator-slot sequencer for the OPL2 core. It divides the master clock enable `cen` into the operator-rate enable `cenop`. It also rotates an 18-bit one-hot `slot` vector, one position per `cenop`, with decoded group/subslot/operator indices. It sits directly upstream of the LFO, envelope and phase stages, which all sample `slot` on `cenop`.

---
 rtl/jtopl_slot.sv | 72 +++++++
 tb/tb_jtopl_slot.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/jtopl_slot.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_slot
// Purpose  : OPL2 operator-slot sequencer: cen divider and one-hot slot walk.
// Revision : 1.0
// ============================================================================
module jtopl_slot #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    output logic        cenop,
    output logic [17:0] slot,
    output logic [1:0]  group,
    output logic [2:0]  subslot,
    output logic        op,
    output logic        zero
);

    localparam logic [2:0] DIV_LAST = 3'(DIV - 1);

    logic [2:0]  div;
    logic        slot_valid;
    logic [17:0] slot_nx;
    logic [2:0]  sub_nx;
    logic [1:0]  grp_nx;

    always_comb begin
        cenop = cen & ~rst & (div == DIV_LAST);
    end

    always_comb begin
        slot_valid = $onehot(slot);
        slot_nx    = {slot[16:0], slot[17]};
        sub_nx     = (subslot >= 3'd5) ? 3'd0 : subslot + 3'd1;
        grp_nx     = group;
        if (subslot >= 3'd5) begin
            grp_nx = (group >= 2'd2) ? 2'd0 : group + 2'd1;
        end
        // A corrupted slot vector restarts the frame instead of propagating
        if (!slot_valid) begin
            slot_nx = 18'd1;
            sub_nx  = 3'd0;
            grp_nx  = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div     <= 3'd0;
            slot    <= 18'd1;
            group   <= 2'd0;
            subslot <= 3'd0;
            op      <= 1'b0;
            zero    <= 1'b1;
        end else begin
            if (cen) begin
                div <= (div == DIV_LAST) ? 3'd0 : div + 3'd1;
            end
            if (cenop) begin
                slot    <= slot_nx;
                group   <= grp_nx;
                subslot <= sub_nx;
                op      <= (sub_nx >= 3'd3);
                zero    <= slot_nx[0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jtopl_slot.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtopl_slot
// Purpose  : Directed self-checking bench for jtopl_slot (DIV = 4, 2, 8).
// Revision : 1.0
// ============================================================================
module tb_jtopl_slot;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cen = 1'b0;
    logic        cenop, op, zero;
    logic [17:0] slot;
    logic [1:0]  group;
    logic [2:0]  subslot;

    logic        cenop2, op2, zero2, cenop8, op8, zero8;
    logic [17:0] slot2, slot8;
    logic [1:0]  group2, group8;
    logic [2:0]  subslot2, subslot8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jtopl_slot #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .cen(cen), .cenop(cenop), .slot(slot),
        .group(group), .subslot(subslot), .op(op), .zero(zero)
    );

    jtopl_slot #(.DIV(2)) dut2 (
        .clk(clk), .rst(rst), .cen(cen), .cenop(cenop2), .slot(slot2),
        .group(group2), .subslot(subslot2), .op(op2), .zero(zero2)
    );

    jtopl_slot #(.DIV(8)) dut8 (
        .clk(clk), .rst(rst), .cen(cen), .cenop(cenop8), .slot(slot8),
        .group(group8), .subslot(subslot8), .op(op8), .zero(zero8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cen = 1'b1;
        tick();
        tick();
        checks++; if (slot !== 18'd1) begin errors++; $display("FAIL reset_slot got %h want %h", slot, 18'd1); end
        checks++; if (group !== 2'd0 || subslot !== 3'd0) begin errors++; $display("FAIL reset_grp_sub got %0d/%0d want 0/0", group, subslot); end
        checks++; if (op !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL reset_op_zero got %b/%b want 0/1", op, zero); end
        checks++; if (cenop !== 1'b0) begin errors++; $display("FAIL reset_cenop got %b want 0", cenop); end
        rst = 1'b0;
        #1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (cenop !== (k == 3)) begin errors++; $display("FAIL first_cenop k=%0d got %b want %b", k, cenop, (k == 3)); end
            checks++; if (slot !== 18'd1) begin errors++; $display("FAIL slot0_hold k=%0d got %h want %h", k, slot, 18'd1); end
        end
        tick();
        checks++; if (slot !== 18'd2) begin errors++; $display("FAIL first_advance got %h want %h", slot, 18'd2); end
        checks++; if (cenop !== 1'b0) begin errors++; $display("FAIL first_cenop_end got %b want 0", cenop); end
    endtask

    task automatic test_walk();
        int i = 1;
        for (int n = 0; n < 18; n++) begin
            checks++; if (slot !== (18'd1 << i)) begin errors++; $display("FAIL walk_slot i=%0d got %h want %h", i, slot, 18'd1 << i); end
            checks++; if (group !== 2'(i / 6) || subslot !== 3'(i % 6)) begin errors++; $display("FAIL walk_grp_sub i=%0d got %0d/%0d want %0d/%0d", i, group, subslot, i / 6, i % 6); end
            checks++; if (op !== ((i % 6) >= 3) || zero !== (i == 0)) begin errors++; $display("FAIL walk_op_zero i=%0d got %b/%b want %b/%b", i, op, zero, ((i % 6) >= 3), (i == 0)); end
            repeat (DIV) tick();
            i = (i + 1) % 18;
        end
    endtask

    task automatic test_random_cen();
        int cen_cnt = 0;
        int op_cnt  = 0;
        int cycles  = 0;
        int idx;
        logic [17:0] p_slot;
        logic [1:0]  p_group;
        logic [2:0]  p_sub;
        logic        p_op, p_zero, p_cen, exp_cenop;
        while (cen_cnt < 5 * 18 * DIV && cycles < 5000) begin
            cen = ($urandom_range(0, 9) < 3);
            #1;
            exp_cenop = cen && ((cen_cnt % DIV) == DIV - 1);
            checks++; if (cenop !== exp_cenop) begin errors++; $display("FAIL rand_cenop cyc=%0d got %b want %b", cycles, cenop, exp_cenop); end
            if (cenop) op_cnt++;
            p_slot = slot; p_group = group; p_sub = subslot; p_op = op; p_zero = zero; p_cen = cen;
            tick();
            cycles++;
            if (p_cen) cen_cnt++;
            if (!p_cen) begin
                checks++;
                if (slot !== p_slot || group !== p_group || subslot !== p_sub || op !== p_op || zero !== p_zero) begin
                    errors++; $display("FAIL rand_frozen cyc=%0d got %h want %h", cycles, slot, p_slot);
                end
            end
            idx = int'(group) * 6 + int'(subslot);
            checks++; if (idx >= 18 || slot !== (18'd1 << idx)) begin errors++; $display("FAIL rand_onehot cyc=%0d got %h want index %0d", cycles, slot, idx); end
            checks++; if (op !== (subslot >= 3'd3) || zero !== slot[0]) begin errors++; $display("FAIL rand_op_zero cyc=%0d got %b/%b want %b/%b", cycles, op, zero, (subslot >= 3'd3), slot[0]); end
        end
        cen = 1'b1;
        checks++; if (cen_cnt != 5 * 18 * DIV) begin errors++; $display("FAIL rand_budget got %0d want %0d", cen_cnt, 5 * 18 * DIV); end
        checks++; if (op_cnt != 5 * 18) begin errors++; $display("FAIL rand_cenop_count got %0d want %0d", op_cnt, 5 * 18); end
        checks++; if (slot !== 18'd2) begin errors++; $display("FAIL rand_end_slot got %h want %h", slot, 18'd2); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cen = 1'b1;
        repeat (11 * DIV + 2) tick();
        checks++; if (slot[11] !== 1'b1 || dut.div !== 3'd2) begin errors++; $display("FAIL mid_setup got %h div %0d want bit11 div 2", slot, dut.div); end
        rst = 1'b1;
        #1;
        checks++; if (cenop !== 1'b0) begin errors++; $display("FAIL mid_rst_cenop got %b want 0", cenop); end
        tick();
        checks++; if (slot !== 18'd1 || dut.div !== 3'd0) begin errors++; $display("FAIL mid_rst_state got %h div %0d want 1 div 0", slot, dut.div); end
        checks++; if (zero !== 1'b1 || cenop !== 1'b0) begin errors++; $display("FAIL mid_rst_zero got %b/%b want 1/0", zero, cenop); end
        rst = 1'b0;
        repeat (DIV - 1) tick();
        checks++; if (cenop !== 1'b1 || slot !== 18'd1) begin errors++; $display("FAIL mid_recover got %b/%h want 1/%h", cenop, slot, 18'd1); end
        tick();
        checks++; if (slot !== 18'd2) begin errors++; $display("FAIL mid_advance got %h want %h", slot, 18'd2); end
    endtask

    task automatic test_force();
        force dut.slot = 18'h00003;
        #1;
        release dut.slot;
        repeat (DIV - 1) tick();
        checks++; if (cenop !== 1'b1) begin errors++; $display("FAIL force_cenop got %b want 1", cenop); end
        tick();
        checks++; if (slot !== 18'd1 || group !== 2'd0 || subslot !== 3'd0) begin errors++; $display("FAIL force_recover got %h %0d/%0d want 1 0/0", slot, group, subslot); end
        checks++; if (zero !== 1'b1 || op !== 1'b0) begin errors++; $display("FAIL force_op_zero got %b/%b want 1/0", zero, op); end
    endtask

    task automatic test_div_variants();
        int c2 = 0;
        int c8 = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cen = 1'b1;
        #1;
        for (int t = 1; t <= 144; t++) begin
            if (cenop2) c2++;
            if (cenop8) c8++;
            tick();
            if (t == 2) begin
                checks++; if (slot2 !== 18'd2) begin errors++; $display("FAIL div2_first got %h want %h", slot2, 18'd2); end
            end
            if (t == 8) begin
                checks++; if (slot8 !== 18'd2) begin errors++; $display("FAIL div8_first got %h want %h", slot8, 18'd2); end
            end
            if (t == 36) begin
                checks++; if (slot2 !== 18'd1) begin errors++; $display("FAIL div2_frame got %h want %h", slot2, 18'd1); end
            end
        end
        checks++; if (c2 != 72) begin errors++; $display("FAIL div2_count got %0d want 72", c2); end
        checks++; if (c8 != 18) begin errors++; $display("FAIL div8_count got %0d want 18", c8); end
        checks++; if (slot8 !== 18'd1) begin errors++; $display("FAIL div8_frame got %h want %h", slot8, 18'd1); end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_random_cen();
        test_mid_reset();
        test_force();
        test_div_variants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
